// File: rtl/snn_pkg.sv
// Shared definitions for the SNN inference pipeline (image loader and core).
package snn_pkg;

    localparam int NUM_PIXELS = 784;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_UNPACK,
        LD_START,
        LD_WAIT_CORE
    } ld_state_t;

endpackage

// File: rtl/image_loader.sv
// Unpacks received image bytes into single-pixel RAM writes, then hands the
// completed image to snn_core with a one-cycle start pulse.
module image_loader
    import snn_pkg::*;
#(
    parameter int NUM_BYTES    = 98,
    parameter int PIX_PER_BYTE = 8,
    parameter int ADDR_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_rdy,
    input  logic [PIX_PER_BYTE-1:0] rx_data,
    input  logic                    core_done,
    input  logic                    clr_overrun,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_data,
    output logic                    start,
    output logic                    loading,
    output logic                    overrun
);

    localparam int BIT_W = $clog2(PIX_PER_BYTE);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_BYTES * PIX_PER_BYTE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(PIX_PER_BYTE - 1);

    ld_state_t               state, state_nxt;
    logic [PIX_PER_BYTE-1:0] hold_q;
    logic                    hold_vld;
    logic [PIX_PER_BYTE-1:0] sreg;
    logic [BIT_W-1:0]        bit_cnt;
    logic [ADDR_W-1:0]       pix_cnt;
    logic                    pop;
    logic                    rx_accept;
    logic                    rx_drop;

    // The write port is driven straight from the registers holding the pixel under way.
    assign ram_addr = pix_cnt;
    assign ram_data = sreg[0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            LD_IDLE: begin
                if (hold_vld) begin
                    pop       = 1'b1;
                    state_nxt = LD_UNPACK;
                end
            end
            LD_UNPACK: begin
                if (bit_cnt == LAST_BIT) begin
                    if (pix_cnt == LAST_PIX) begin
                        state_nxt = LD_START;
                    end else if (hold_vld) begin
                        pop = 1'b1;              // back-to-back byte, no idle bubble
                    end else begin
                        state_nxt = LD_IDLE;
                    end
                end
            end
            LD_START:     state_nxt = LD_WAIT_CORE;
            LD_WAIT_CORE: if (core_done) state_nxt = LD_IDLE;
            default:      state_nxt = LD_IDLE;
        endcase
    end

    // Bytes arriving while the core owns the RAM are never buffered.
    always_comb begin
        rx_accept = rx_rdy && (state != LD_WAIT_CORE) && (!hold_vld || pop);
        rx_drop   = rx_rdy && !rx_accept;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= LD_IDLE;
            hold_q   <= '0;
            hold_vld <= 1'b0;
            sreg     <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            ram_we   <= 1'b0;
            start    <= 1'b0;
            loading  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_vld <= rx_accept || (hold_vld && !pop);
            if (rx_accept) hold_q <= rx_data;

            if (pop) begin
                sreg <= hold_q;
            end else if (state == LD_UNPACK) begin
                sreg <= sreg >> 1;
            end

            if (state == LD_UNPACK) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
            end

            ram_we <= (state_nxt == LD_UNPACK);
            start  <= (state_nxt == LD_START);

            if (state_nxt == LD_START) begin
                loading <= 1'b0;
            end else if (state == LD_IDLE && pop) begin
                loading <= 1'b1;
            end

            // A fresh drop outranks a simultaneous clear.
            if (rx_drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed and randomized checks of image_loader against a pixel-stream model.
module tb_image_loader;
    import snn_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       core_done = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       start;
    logic       loading;
    logic       overrun;

    image_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .core_done  (core_done),
        .clr_overrun(clr_overrun),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .start      (start),
        .loading    (loading),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic       pix;
    } wr_t;

    int   n_assert  = 0;
    int   n_fail    = 0;
    wr_t  exp_q[$];
    int   model_pix = 0;
    int   wr_cnt    = 0;
    int   start_cnt = 0;
    int   run_len   = 0;
    int   last_run  = 0;
    logic ram_mem [0:1023];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: each accepted byte yields eight writes at consecutive pixel indices, LSB first.
    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{addr: 10'(model_pix), pix: b[i]});
            model_pix = (model_pix + 1) % NUM_PIXELS;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit accepted);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        if (accepted) push_byte(b);
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic pulse_core_done();
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start(input int budget);
        int s0;
        bit seen;
        s0   = start_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (start_cnt != s0) seen = 1'b1;
        end
        check("start_seen", seen, 1);
        repeat (10) @(negedge clk);
        check("start_pulse_count", start_cnt - s0, 1);
        check("loading_after_start", loading, 0);
        check("we_after_start", ram_we, 0);
    endtask

    task automatic send_random_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(9, 20)) @(negedge clk);
            send_byte(8'($urandom), 1'b1);
        end
    endtask

    // RAM stand-in and write checker.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                wr_t w;
                wr_cnt++;
                run_len++;
                ram_mem[ram_addr] = ram_data;
                if (exp_q.size() == 0) begin
                    check("spurious_we", ram_we, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", ram_addr, w.addr);
                    check("wr_data", ram_data, w.pix);
                end
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
            if (start) start_cnt++;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_start", start, 0);
        check("rst_loading", loading, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // 1: full image of 0xA5, widely spaced
        wr_cnt = 0;
        for (int i = 0; i < 98; i++) begin
            repeat (100) @(negedge clk);
            send_byte(8'hA5, 1'b1);
            if (i == 50) begin
                repeat (12) @(negedge clk);
                check("loading_mid_image", loading, 1);
            end
        end
        wait_start(100);
        check("t1_write_count", wr_cnt, 784);
        check("t1_addr_783", ram_mem[783], 1);
        check("t1_addr_6", ram_mem[6], 0);
        pulse_core_done();
        repeat (5) @(negedge clk);

        // 2 + 6: latency and back-to-back unpack of two bytes 3 cycles apart
        wr_cnt   = 0;
        last_run = 0;
        @(negedge clk);
        rx_data = 8'h01;
        rx_rdy  = 1'b1;
        push_byte(8'h01);
        @(negedge clk);
        rx_rdy = 1'b0;
        check("lat_n1_we", ram_we, 0);
        @(negedge clk);
        check("lat_n2_we", ram_we, 1);
        check("lat_n2_addr", ram_addr, 0);
        @(negedge clk);
        rx_data = 8'h80;
        rx_rdy  = 1'b1;
        push_byte(8'h80);
        @(negedge clk);
        rx_rdy = 1'b0;
        wait_drain(100);
        check("t2_write_count", wr_cnt, 16);
        check("t2_run_length", last_run, 16);
        check("t2_addr0", ram_mem[0], 1);
        check("t2_addr15", ram_mem[15], 1);
        check("t2_addr7", ram_mem[7], 0);
        check("t2_addr8", ram_mem[8], 0);
        check("t2_overrun", overrun, 0);

        // 3: three consecutive bytes, the third is dropped
        @(negedge clk);
        rx_data = 8'h3C;
        rx_rdy  = 1'b1;
        push_byte(8'h3C);
        @(negedge clk);
        rx_data = 8'hC3;
        push_byte(8'hC3);
        @(negedge clk);
        check("t3_no_early_overrun", overrun, 0);
        rx_data = 8'hFF;
        @(negedge clk);
        rx_rdy = 1'b0;
        check("t3_overrun_set", overrun, 1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("t3_overrun_cleared", overrun, 0);
        wait_drain(100);

        // 4: finish the image, then bytes during WAIT_CORE are dropped
        send_random_bytes((NUM_PIXELS - model_pix) / 8);
        wait_start(100);
        wr_cnt = 0;
        send_byte(8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        clr_overrun = 1'b1;
        send_byte(8'hFF, 1'b0);
        clr_overrun = 1'b0;
        check("t4_overrun_set_wins", overrun, 1);
        repeat (20) @(negedge clk);
        check("t4_no_writes_wait", wr_cnt, 0);
        pulse_core_done();
        repeat (20) @(negedge clk);
        check("t4_no_writes_after_done", wr_cnt, 0);
        check("t4_model_at_zero", model_pix, 0);
        send_byte(8'h5A, 1'b1);
        wait_drain(100);
        check("t4_new_image_writes", wr_cnt, 8);

        // 5: reset mid-image, then a fresh image
        send_random_bytes(39);
        repeat (3) @(negedge clk);
        check("t5_overrun_before_rst", overrun, 1);
        check("t5_we_before_rst", ram_we, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_we", ram_we, 0);
        check("t5_rst_addr", ram_addr, 0);
        check("t5_rst_data", ram_data, 0);
        check("t5_rst_start", start, 0);
        check("t5_rst_loading", loading, 0);
        check("t5_rst_overrun", overrun, 0);
        exp_q.delete();
        model_pix = 0;
        rst       = 1'b0;
        wr_cnt    = 0;
        send_random_bytes(98);
        wait_start(100);
        check("t5_write_count", wr_cnt, 784);
        pulse_core_done();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
